// File: rtl/adder_bist_checker.sv
// Built-in self-test controller for a combinational ripple-carry adder.
// Sweeps every {a, b, cin} vector into the adder under test, compares
// {cout, sum} against a golden a+b+cin, and reports pass/fail, a saturating
// error count and the index of the first failing vector.
module adder_bist_checker #(
  parameter  int WIDTH = 4,
  parameter  int ERRW  = 8,
  localparam int VW    = 2 * WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [VW-1:0]    first_fail
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [VW-1:0]   LAST_VEC = {VW{1'b1}};
  localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

  state_t          state;
  state_t          state_next;
  logic [VW-1:0]   vec;
  logic [WIDTH:0]  expected;
  logic            mismatch;

  // Vector register drives the adder under test directly: a in the MSBs, cin in the LSB.
  assign dut_a   = vec[VW-1 -: WIDTH];
  assign dut_b   = vec[WIDTH:1];
  assign dut_cin = vec[0];

  // Golden response, one bit wider than the operands so the carry-out is kept.
  assign expected = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign mismatch = ({dut_cout, dut_sum} != expected);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; a start in IDLE or DONE launches a run.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_APPLY;
      end
      S_APPLY: begin
        busy       = 1'b1;
        state_next = S_CHECK;
      end
      S_CHECK: begin
        busy       = 1'b1;
        state_next = (vec == LAST_VEC) ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) state_next = S_APPLY;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Vector counter and result registers: cleared on start, updated only in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec        <= '0;
            err_count  <= '0;
            first_fail <= '0;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            // The first mismatch of a run is the only one that records its vector.
            if (err_count == '0) first_fail <= vec;
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
          end
          if (vec != LAST_VEC) vec <= vec + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Self-checking bench: two BIST instances (WIDTH=1 and WIDTH=4) each drive a
// behavioural adder with selectable faults; a reference model predicts the
// run result at start time and a monitor compares it when done rises.
module tb_adder_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Fault modes: 0 ideal, 1 sum[0] stuck-at-1, 2 cout stuck-at-0, 3 flip sum[0] on marked vectors.
  int mode1 = 0;
  int mode4 = 0;
  bit bad1 [8];
  bit bad4 [512];

  function automatic int model_add(input int w, input int mode, input int v, input bit flip);
    int a, b, c, r;
    a = v >> (w + 1);
    b = (v >> 1) & ((1 << w) - 1);
    c = v & 1;
    r = a + b + c;
    case (mode)
      1: r = r | 1;
      2: r = r & ~(1 << w);
      3: if (flip) r = r ^ 1;
      default: ;
    endcase
    return r;
  endfunction

  // WIDTH=1 instance
  logic       rst1, start1, cin1, cout1, busy1, done1, pass1;
  logic [0:0] a1, b1, sum1;
  logic [7:0] err1;
  logic [2:0] ff1;
  int         r1;

  adder_bist_checker #(.WIDTH(1), .ERRW(8)) u1 (
    .clk(clk), .rst(rst1), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1),
    .dut_sum(sum1), .dut_cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  always_comb begin
    r1    = model_add(1, mode1, int'({a1, b1, cin1}), bad1[{a1, b1, cin1}]);
    sum1  = r1[0:0];
    cout1 = r1[1];
  end

  // WIDTH=4 instance
  logic       rst4, start4, cin4, cout4, busy4, done4, pass4;
  logic [3:0] a4, b4, sum4;
  logic [7:0] err4;
  logic [8:0] ff4;
  int         r4;

  adder_bist_checker #(.WIDTH(4), .ERRW(8)) u4 (
    .clk(clk), .rst(rst4), .start(start4),
    .dut_a(a4), .dut_b(b4), .dut_cin(cin4),
    .dut_sum(sum4), .dut_cout(cout4),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_fail(ff4)
  );

  always_comb begin
    r4    = model_add(4, mode4, int'({a4, b4, cin4}), bad4[{a4, b4, cin4}]);
    sum4  = r4[3:0];
    cout4 = r4[4];
  end

  // Expected outcome of one run, including the cycle count at which done is seen.
  typedef struct {
    int err;
    int first;
    int pass;
    int cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  // Reference: exhaustive sweep with plain arithmetic, counting and saturating.
  function automatic exp_t reference(input int w, input int mode, input int start_edge);
    exp_t e;
    int   n, cnt, first, a, b, c, golden, got;
    bit   flip;
    n     = 1 << (2 * w + 1);
    cnt   = 0;
    first = -1;
    for (int v = 0; v < n; v++) begin
      a      = v >> (w + 1);
      b      = (v >> 1) & ((1 << w) - 1);
      c      = v & 1;
      golden = a + b + c;
      flip   = (w == 1) ? bad1[v] : bad4[v];
      got    = model_add(w, mode, v, flip);
      if (got != golden) begin
        cnt++;
        if (first < 0) first = v;
      end
    end
    e.err   = (cnt > 255) ? 255 : cnt;
    e.first = (first < 0) ? 0 : first;
    e.pass  = (cnt == 0) ? 1 : 0;
    e.cyc   = start_edge + 2 * n + 1;
    return e;
  endfunction

  // Monitors: pop an expectation on each rising done and compare.
  logic done1_q = 1'b0;
  logic done4_q = 1'b0;

  always @(negedge clk) begin
    if (done1 && !done1_q) begin
      if (q1.size() == 0) begin
        check("w1 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("w1 err_count",  err1,  e.err);
        check("w1 first_fail", ff1,   e.first);
        check("w1 pass",       pass1, e.pass);
        check("w1 done cycle", cyc,   e.cyc);
      end
    end
    done1_q <= done1;
  end

  always @(negedge clk) begin
    if (done4 && !done4_q) begin
      if (q4.size() == 0) begin
        check("w4 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w4 err_count",  err4,  e.err);
        check("w4 first_fail", ff4,   e.first);
        check("w4 pass",       pass4, e.pass);
        check("w4 done cycle", cyc,   e.cyc);
      end
    end
    done4_q <= done4;
  end

  task automatic run1();
    @(negedge clk);
    start1 = 1'b1;
    q1.push_back(reference(1, mode1, cyc));
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic run4(input bit expect_result);
    @(negedge clk);
    start4 = 1'b1;
    if (expect_result) q4.push_back(reference(4, mode4, cyc));
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait1(input int budget);
    int k = 0;
    while (q1.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("w1 run timeout", q1.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait4(input int budget);
    int k = 0;
    while (q4.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("w4 run timeout", q4.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, dens, k;
    rst1 = 1'b1; rst4 = 1'b1; start1 = 1'b0; start4 = 1'b0;
    foreach (bad1[i]) bad1[i] = 1'b0;
    foreach (bad4[i]) bad4[i] = 1'b0;
    #12;
    check("w1 reset outs", {busy1, done1, pass1, a1, b1, cin1}, 0);
    check("w1 reset err",  err1, 0);
    check("w1 reset ff",   ff1,  0);
    check("w4 reset outs", {busy4, done4, pass4, a4, b4, cin4}, 0);
    check("w4 reset err",  err4, 0);
    check("w4 reset ff",   ff4,  0);
    @(negedge clk);
    rst1 = 1'b0; rst4 = 1'b0;

    // WIDTH=1 ideal run with the vector sweep checked cycle by cycle.
    @(negedge clk);
    start1 = 1'b1;
    q1.push_back(reference(1, 0, cyc));
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      start1 = 1'b0;
      check("w1 sweep vector", {a1, b1, cin1}, j / 2);
      check("w1 sweep busy",   busy1, 1);
    end
    wait1(40);

    // sum[0] stuck-at-1: mismatches at 0, 3, 5, 6.
    mode1 = 1;
    run1();
    wait1(40);

    // Start pulsed while busy is ignored.
    mode1 = 0;
    run1();
    repeat (4) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait1(40);

    // Failing run with a nonzero first failure, then restart from DONE.
    mode1 = 3;
    foreach (bad1[i]) bad1[i] = ($urandom_range(0, 1) == 1);
    bad1[0] = 1'b0;
    bad1[5] = 1'b1;
    run1();
    wait1(40);
    repeat (3) @(negedge clk);
    check("w1 done holds", done1, 1);
    mode1 = 0;
    start1 = 1'b1;
    q1.push_back(reference(1, 0, cyc));
    @(negedge clk);
    start1 = 1'b0;
    check("w1 restart busy", busy1, 1);
    check("w1 restart done", done1, 0);
    check("w1 restart err",  err1,  0);
    check("w1 restart ff",   ff1,   0);
    wait1(40);

    // start held high: done lasts one cycle and the run restarts.
    @(negedge clk);
    e = cyc;
    start1 = 1'b1;
    q1.push_back(reference(1, 0, e));
    q1.push_back(reference(1, 0, e + 17));
    repeat (18) @(negedge clk);
    check("w1 held done width", done1, 0);
    check("w1 held rebusy",     busy1, 1);
    start1 = 1'b0;
    wait1(40);

    // Random WIDTH=1 runs.
    for (int it = 0; it < 6; it++) begin
      mode1 = $urandom_range(0, 3);
      foreach (bad1[i]) bad1[i] = ($urandom_range(0, 2) == 0);
      run1();
      wait1(40);
    end

    // WIDTH=4 ideal and cout stuck-at-0 (saturates at 255, first fail 31).
    mode4 = 0;
    run4(1'b1);
    wait4(1100);
    mode4 = 2;
    run4(1'b1);
    wait4(1100);

    // Reset mid-run at vector 100 clears everything asynchronously.
    mode4 = 0;
    run4(1'b0);
    k = 0;
    while ({a4, b4, cin4} != 9'd100 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("w4 reach vec 100", {a4, b4, cin4}, 100);
    #2 rst4 = 1'b1;
    #1;
    check("w4 abort outs", {busy4, done4, pass4, a4, b4, cin4}, 0);
    check("w4 abort err",  err4, 0);
    check("w4 abort ff",   ff4,  0);
    @(negedge clk);
    rst4 = 1'b0;
    run4(1'b1);
    wait4(1100);

    // Random WIDTH=4 fault masks, one dense enough to saturate.
    for (int it = 0; it < 3; it++) begin
      mode4 = 3;
      dens = (it == 2) ? 70 : $urandom_range(0, 4);
      foreach (bad4[i]) bad4[i] = ($urandom_range(0, 99) < dens);
      run4(1'b1);
      wait4(1100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
